prog_and_sched: RTL
===================

// Module: prog_and_sched
// PURPOSE
//  - Shares one WIDTH-bit, STAGES-level registered prefix-AND pipeline between two requesters.
//  - Round-robin arbiter, per-stage valid/ID tracking, global stall on output backpressure.
//  - Returns each result tagged with the originating requester ID.
//  - Sits between the two request sources and the downstream result consumer.
// PARAMETERS
//  - WIDTH   3  bits per operand / result
//  - STAGES  2  prefix-AND levels; each level is registered; >=1
// PORTS
//  - clk         in   1      rising-edge clock
//  - rst_n       in   1      asynchronous, active-low reset
//  - req0_valid  in   1      requester 0 has an operand
//  - req0_data   in   WIDTH  requester 0 operand
//  - req0_ready  out  1      requester 0 operand accepted this cycle
//  - req1_valid  in   1      requester 1 has an operand
//  - req1_data   in   WIDTH  requester 1 operand
//  - req1_ready  out  1      requester 1 operand accepted this cycle
//  - res_valid   out  1      result available
//  - res_data    out  WIDTH  result
//  - res_id      out  1      requester that issued res_data
//  - res_ready   in   1      consumer takes result
//  - busy        out  1      any pipeline stage holds a valid entry
// BEHAVIOUR
//  - Structure: capture register (level 0), then STAGES registered prefix-AND levels.
//    - Last level drives res_*; each register holds {valid, id, data}.
//  - Prefix-AND per level: out[0]=in[0]; out[i]=in[i] & out[i-1], for i=1..WIDTH-1.
//  - Advance: adv = !res_valid | res_ready.
//    - adv=1: all levels shift one place; level 0 loads the granted operand, or a bubble (valid=0).
//    - adv=0: every register holds; res_* held stable; no request accepted.
//  - Arbitration is combinational from the valids and last_grant.
//    - One valid: that requester wins.
//    - Both valid: grant != last_grant.
//    - last_grant updates only on an accepted transfer; it holds on stall or idle.
//    - reqN_ready = adv & grant==N. Both readies are never high together.
//  - Accept = reqN_valid & reqN_ready at a rising edge.
//  - Latency: operand accepted at edge k appears on res_* after edge k+STAGES, when no stall occurs.
//    - Each stall cycle adds exactly one cycle.
//  - Throughput: one operand per cycle while res_ready=1. Bubbles are not collapsed.
//  - Output transfer: res_valid & res_ready. In the same edge, the next level (or a bubble) moves in.
//  - busy = OR of all level valid bits.
//  - Reset (async assert, sync-to-clk deassert handled upstream):
//    - All valid bits=0; data=0; id=0; last_grant=1 (req0 wins first tie).
//    - Outputs: res_valid=0, res_data=0, res_id=0, busy=0.
//    - Readies follow the combinational rules (adv=1 after reset).
//    - Mid-operation reset discards all in-flight entries; no partial result is emitted.
//  - Requesters may drop valid without a handshake; the arbiter re-evaluates every cycle.
// CONFIGURATION
//  - PROG_AND_STATS_EN defined: adds outputs
//    - acc0_cnt[15:0], acc1_cnt[15:0]: accepts per requester.
//    - stall_cnt[15:0]: cycles with res_valid & !res_ready.
//    - All saturate at 16'hFFFF and reset to 0.
//  - PROG_AND_STATS_EN undefined: those ports and counters are absent. Datapath, timing and
//    handshake behaviour are identical in both builds.
// TESTING (WIDTH=3, STAGES=2)
//  - Single op: req0 3'b011 at edge k, res_ready=1
//    -> res_valid=1, res_data=3'b011, res_id=0 after edge k+2; busy low after the result leaves.
//  - Prefix values: req1 sends 3'b101, 3'b110, 3'b111 back-to-back
//    -> results 3'b001, 3'b000, 3'b111 on consecutive cycles, all with res_id=1.
//  - Tie: both valid continuously after reset
//    -> grants alternate 0,1,0,1; res_id sequence matches; neither starves.
//  - Stall: hold res_ready=0 for 3 cycles with 3 ops in flight
//    -> res_* stable; both readies 0; no entry lost or duplicated; stream resumes in order.
//    -> With stats: stall_cnt=3.
//  - Reset mid-flight: assert rst_n=0 with 2 entries in flight
//    -> res_valid, busy and res_data drop to 0 immediately (async); no result after release.
//    -> First tie after reset goes to req0.
//  - Stats saturation (PROG_AND_STATS_EN): 65540 req0 accepts -> acc0_cnt=16'hFFFF.

Source files
------------

// File: rtl/prog_and_sched.sv
// Two-requester round-robin front end sharing one registered prefix-AND pipeline.
// Optional statistics counters are enabled by defining PROG_AND_STATS_EN.
module prog_and_sched #(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req0_valid,
   input  logic [WIDTH-1:0] i_req0_data,
   output logic             o_req0_ready,
   input  logic             i_req1_valid,
   input  logic [WIDTH-1:0] i_req1_data,
   output logic             o_req1_ready,
   output logic             o_res_valid,
   output logic [WIDTH-1:0] o_res_data,
   output logic             o_res_id,
   input  logic             i_res_ready,
`ifdef PROG_AND_STATS_EN
   output logic             o_busy,
   output logic [15:0]      o_acc0_cnt,
   output logic [15:0]      o_acc1_cnt,
   output logic [15:0]      o_stall_cnt
`else
   output logic             o_busy
`endif
);

   function automatic logic [WIDTH-1:0] prefix_and(input logic [WIDTH-1:0] a);
      logic [WIDTH-1:0] o;
      o[0] = a[0];
      for (int unsigned i = 1; i < WIDTH; i++) o[i] = a[i] & o[i-1];
      return o;
   endfunction

   // Level 0 is the raw capture register; levels 1..STAGES each apply one prefix-AND.
   logic [STAGES:0]  r_vld;
   logic [STAGES:0]  r_id;
   logic [WIDTH-1:0] r_data [0:STAGES];
   logic             r_last_grant;

   logic             w_adv;
   logic             w_any;
   logic             w_grant;
   logic             w_accept;
   logic [WIDTH-1:0] w_sel_data;

   always_comb begin
      w_adv        = !r_vld[STAGES] | i_res_ready;
      w_any        = i_req0_valid | i_req1_valid;
      w_grant      = i_req1_valid;
      if (i_req0_valid & i_req1_valid) w_grant = ~r_last_grant;
      w_accept     = w_adv & w_any;
      w_sel_data   = w_grant ? i_req1_data : i_req0_data;
      o_req0_ready = w_adv & i_req0_valid & ~w_grant;
      o_req1_ready = w_adv & i_req1_valid & w_grant;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld        <= '0;
         r_id         <= '0;
         r_last_grant <= 1'b1;
         for (int unsigned i = 0; i <= STAGES; i++) r_data[i] <= '0;
      end else if (w_adv) begin
         r_vld     <= {r_vld[STAGES-1:0], w_accept};
         r_id      <= {r_id[STAGES-1:0], w_accept & w_grant};
         // Bubbles carry zero data so an empty output always reads as zero.
         r_data[0] <= w_accept ? w_sel_data : '0;
         for (int unsigned i = 1; i <= STAGES; i++) r_data[i] <= prefix_and(r_data[i-1]);
         if (w_accept) r_last_grant <= w_grant;
      end
   end

   assign o_res_valid = r_vld[STAGES];
   assign o_res_data  = r_data[STAGES];
   assign o_res_id    = r_id[STAGES];
   assign o_busy      = |r_vld;

`ifdef PROG_AND_STATS_EN
   logic [15:0] r_acc0_cnt;
   logic [15:0] r_acc1_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc0_cnt  <= '0;
         r_acc1_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (o_req0_ready && r_acc0_cnt != 16'hFFFF) r_acc0_cnt <= r_acc0_cnt + 16'd1;
         if (o_req1_ready && r_acc1_cnt != 16'hFFFF) r_acc1_cnt <= r_acc1_cnt + 16'd1;
         if (r_vld[STAGES] && !i_res_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign o_acc0_cnt  = r_acc0_cnt;
   assign o_acc1_cnt  = r_acc1_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
